// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin memory arbiter with stall lock and in-order read tag FIFO
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_req0,
    input  logic                         i_req1,
    input  logic                         i_we0,
    input  logic                         i_we1,
    input  logic [ADDR_W-1:0]            i_addr0,
    input  logic [ADDR_W-1:0]            i_addr1,
    input  logic [DATA_W-1:0]            i_wdata0,
    input  logic [DATA_W-1:0]            i_wdata1,
    output logic                         o_gnt0,
    output logic                         o_gnt1,
    output logic                         o_rvalid0,
    output logic                         o_rvalid1,
    output logic [DATA_W-1:0]            o_rdata0,
    output logic [DATA_W-1:0]            o_rdata1,
    output logic                         o_mem_req,
    output logic                         o_mem_we,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic [DATA_W-1:0]            o_mem_wdata,
    input  logic                         i_mem_ready,
    input  logic                         i_mem_rvalid,
    input  logic [DATA_W-1:0]            i_mem_rdata,
    output logic [$clog2(MAX_OUTST):0]   o_outst_cnt,
    output logic                         o_err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTST);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic             r_rr_ptr;
    logic             r_lock_sel;
    logic             r_orphan;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_tags [MAX_OUTST];

    logic w_full;
    logic w_empty;
    logic w_elig0;
    logic w_elig1;
    logic w_sel;
    logic w_mem_req;
    logic w_sel_we;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Full flag comes from the registered count, so a same-cycle pop never unblocks a read.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_elig0 = i_req0 && (i_we0 || !w_full);
    assign w_elig1 = i_req1 && (i_we1 || !w_full);

    always_comb begin
        w_sel     = 1'b0;
        w_mem_req = 1'b0;
        if (!i_rst) begin
            if (r_state == S_HOLD) begin
                w_sel     = r_lock_sel;
                w_mem_req = 1'b1;
            end else begin
                w_sel     = (w_elig0 && w_elig1) ? r_rr_ptr : w_elig1;
                w_mem_req = w_elig0 || w_elig1;
            end
        end
    end

    assign w_sel_we    = w_sel ? i_we1 : i_we0;
    assign o_mem_req   = w_mem_req;
    assign o_mem_we    = w_mem_req && w_sel_we;
    assign o_mem_addr  = w_mem_req ? (w_sel ? i_addr1 : i_addr0) : '0;
    assign o_mem_wdata = w_mem_req ? (w_sel ? i_wdata1 : i_wdata0) : '0;

    assign w_accept = w_mem_req && i_mem_ready;
    assign o_gnt0   = w_accept && !w_sel;
    assign o_gnt1   = w_accept && w_sel;
    assign w_push   = w_accept && !w_sel_we;

    assign w_pop     = i_mem_rvalid && !w_empty;
    assign w_head    = r_tags[r_rd_ptr];
    assign o_rvalid0 = w_pop && !w_head;
    assign o_rvalid1 = w_pop && w_head;
    assign o_rdata0  = i_mem_rdata;
    assign o_rdata1  = i_mem_rdata;

    assign o_outst_cnt  = r_count;
    assign o_err_orphan = r_orphan;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_sel;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_lock_sel <= 1'b0;
            r_orphan   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_req && !i_mem_ready) begin
                        r_state    <= S_HOLD;
                        r_lock_sel <= w_sel;
                    end
                end
                default: begin
                    if (i_mem_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase

            // r_rr_ptr holds the port preferred on the next tie: the one not granted last.
            if (w_accept) begin
                r_rr_ptr <= !w_sel;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_mem_rvalid && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a queue model
module tb_mem_port_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [2:0]  outst_cnt;
    logic        err_orphan;

    int total = 0;
    int bad   = 0;

    int m_q[$];
    int m_pref;
    int m_lock;
    bit m_orph;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAXO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_outst_cnt(outst_cnt), .o_err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
        m_q.delete();
        m_pref = 0;
        m_lock = -1;
        m_orph = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0 = 1;
        @(negedge clk);
        total++;
        if ({mem_req, gnt0, gnt1, rvalid0, rvalid1, err_orphan} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000", {mem_req, gnt0, gnt1, rvalid0, rvalid1, err_orphan});
        end
        total++;
        if (outst_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_outst got=%0d want=0", outst_cnt);
        end
        do_reset();
        @(negedge clk);
        total++;
        if ({mem_req, gnt0, gnt1, mem_addr} !== 35'b0) begin
            bad++;
            $display("FAIL post_reset_idle req=%b addr=%h want 0", mem_req, mem_addr);
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h10; mem_ready = 1;
        @(negedge clk);
        total++;
        if (!(gnt0 === 1 && gnt1 === 0 && mem_req === 1 && mem_addr === 32'h10)) begin
            bad++;
            $display("FAIL single_grant gnt0=%b gnt1=%b addr=%h want 1 0 10", gnt0, gnt1, mem_addr);
        end
        next_cycle();
        req0 = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
        @(negedge clk);
        total++;
        if (!(rvalid0 === 1 && rvalid1 === 0 && rdata0 === 32'hCAFE && outst_cnt === 3'd1)) begin
            bad++;
            $display("FAIL single_resp rv0=%b rv1=%b rdata0=%h cnt=%0d want 1 0 cafe 1", rvalid0, rvalid1, rdata0, outst_cnt);
        end
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        total++;
        if (outst_cnt !== 3'd0) begin
            bad++;
            $display("FAIL single_drain got=%0d want=0", outst_cnt);
        end
        next_cycle();
    endtask

    task automatic test_alternate();
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        addr0 = 32'h100; addr1 = 32'h200; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (!(gnt0 === (i % 2 == 0) && gnt1 === (i % 2 == 1) && mem_addr === ((i % 2 == 1) ? 32'h200 : 32'h100))) begin
                bad++;
                $display("FAIL alt_grant%0d gnt0=%b gnt1=%b addr=%h want port %0d", i, gnt0, gnt1, mem_addr, i % 2);
            end
            next_cycle();
        end
        req0 = 0; req1 = 0; mem_ready = 0;
        @(negedge clk);
        total++;
        if (outst_cnt !== 3'd4) begin
            bad++;
            $display("FAIL alt_outst got=%0d want=4", outst_cnt);
        end
        next_cycle();
        for (int r = 0; r < 4; r++) begin
            mem_rvalid = 1; mem_rdata = 32'hA + r;
            @(negedge clk);
            total++;
            if (!(rvalid0 === (r % 2 == 0) && rvalid1 === (r % 2 == 1) && rdata0 === 32'hA + r && rdata1 === 32'hA + r)) begin
                bad++;
                $display("FAIL alt_resp%0d rv0=%b rv1=%b rdata=%h want port %0d data %h", r, rvalid0, rvalid1, rdata0, r % 2, 32'hA + r);
            end
            next_cycle();
        end
        mem_rvalid = 0;
    endtask

    task automatic test_hold();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h30; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (!(mem_req === 1 && mem_addr === 32'h30 && gnt0 === 0 && gnt1 === 0)) begin
                bad++;
                $display("FAIL hold_stall%0d addr=%h gnt0=%b gnt1=%b want 30 0 0", i, mem_addr, gnt0, gnt1);
            end
            next_cycle();
            req1 = 1; we1 = 0; addr1 = 32'h40;
        end
        mem_ready = 1;
        @(negedge clk);
        total++;
        if (!(gnt0 === 1 && gnt1 === 0 && mem_addr === 32'h30)) begin
            bad++;
            $display("FAIL hold_release gnt0=%b gnt1=%b addr=%h want 1 0 30", gnt0, gnt1, mem_addr);
        end
        next_cycle();
        req0 = 0;
        @(negedge clk);
        total++;
        if (!(gnt1 === 1 && gnt0 === 0 && mem_addr === 32'h40)) begin
            bad++;
            $display("FAIL hold_next gnt1=%b addr=%h want 1 40", gnt1, mem_addr);
        end
        next_cycle();
        req1 = 0; mem_ready = 0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        req1 = 1; we1 = 0; addr1 = 32'h60; mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (gnt1 !== 1'b1) begin
                bad++;
                $display("FAIL full_fill%0d gnt1=%b want 1", i, gnt1);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (!(gnt1 === 0 && mem_req === 0 && outst_cnt === 3'd4)) begin
            bad++;
            $display("FAIL full_block gnt1=%b req=%b cnt=%0d want 0 0 4", gnt1, mem_req, outst_cnt);
        end
        next_cycle();
        req0 = 1; we0 = 1; addr0 = 32'h50; wdata0 = 32'h55;
        @(negedge clk);
        total++;
        if (!(gnt0 === 1 && gnt1 === 0 && mem_we === 1 && mem_wdata === 32'h55)) begin
            bad++;
            $display("FAIL full_write gnt0=%b we=%b wdata=%h want 1 1 55", gnt0, mem_we, mem_wdata);
        end
        next_cycle();
        req0 = 0; we0 = 0; mem_rvalid = 1; mem_rdata = 32'h1;
        @(negedge clk);
        total++;
        if (!(rvalid1 === 1 && gnt1 === 0)) begin
            bad++;
            $display("FAIL full_pop rv1=%b gnt1=%b want 1 0", rvalid1, gnt1);
        end
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        total++;
        if (!(gnt1 === 1 && outst_cnt === 3'd3)) begin
            bad++;
            $display("FAIL full_fifth gnt1=%b cnt=%0d want 1 3", gnt1, outst_cnt);
        end
        next_cycle();
        req1 = 0;
        @(negedge clk);
        total++;
        if (outst_cnt !== 3'd4) begin
            bad++;
            $display("FAIL full_refill cnt=%0d want 4", outst_cnt);
        end
        next_cycle();
    endtask

    task automatic test_orphan();
        do_reset();
        mem_rvalid = 1; mem_rdata = 32'hDEAD;
        @(negedge clk);
        total++;
        if (!(rvalid0 === 0 && rvalid1 === 0)) begin
            bad++;
            $display("FAIL orphan_pulse rv0=%b rv1=%b want 0 0", rvalid0, rvalid1);
        end
        next_cycle();
        mem_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (err_orphan !== 1'b1) begin
                bad++;
                $display("FAIL orphan_sticky%0d got=%b want 1", i, err_orphan);
            end
            next_cycle();
        end
        do_reset();
        @(negedge clk);
        total++;
        if (err_orphan !== 1'b0) begin
            bad++;
            $display("FAIL orphan_clear got=%b want 0", err_orphan);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h70; mem_ready = 1;
        next_cycle();
        next_cycle();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h80; mem_ready = 0;
        @(negedge clk);
        total++;
        if (!(mem_req === 1 && outst_cnt === 3'd2 && gnt1 === 0)) begin
            bad++;
            $display("FAIL mid_setup req=%b cnt=%0d gnt1=%b want 1 2 0", mem_req, outst_cnt, gnt1);
        end
        next_cycle();
        @(negedge clk);
        #1;
        rst = 1; req1 = 0;
        #1;
        total++;
        if (!(outst_cnt === 3'd0 && mem_req === 0)) begin
            bad++;
            $display("FAIL mid_reset cnt=%0d req=%b want 0 0", outst_cnt, mem_req);
        end
        next_cycle();
        rst = 0;
        mem_rvalid = 1;
        @(negedge clk);
        total++;
        if (!(rvalid0 === 0 && rvalid1 === 0)) begin
            bad++;
            $display("FAIL mid_stale_resp rv0=%b rv1=%b want 0 0", rvalid0, rvalid1);
        end
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        total++;
        if (err_orphan !== 1'b1) begin
            bad++;
            $display("FAIL mid_orphan got=%b want 1", err_orphan);
        end
        next_cycle();
    endtask

    task automatic test_random(input int n);
        bit e0, e1, e_req, e_sel, e_we, e_g0, e_g1, e_rv0, e_rv1, e_pop, e_orph_evt;
        logic [31:0] e_addr, e_wdata;
        do_reset();
        for (int c = 0; c < n; c++) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; we0 = ($urandom_range(0, 3) == 0); addr0 = $urandom; wdata0 = $urandom;
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; we1 = ($urandom_range(0, 3) == 0); addr1 = $urandom; wdata1 = $urandom;
            end
            mem_ready  = ($urandom_range(0, 3) != 0);
            mem_rvalid = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
            mem_rdata  = $urandom;
            @(negedge clk);
            if (m_lock >= 0) begin
                e_req = 1; e_sel = (m_lock == 1);
            end else begin
                e0 = req0 && (we0 || m_q.size() < MAXO);
                e1 = req1 && (we1 || m_q.size() < MAXO);
                e_req = e0 || e1;
                e_sel = (e0 && e1) ? (m_pref == 1) : e1;
            end
            e_we    = e_req && (e_sel ? we1 : we0);
            e_addr  = e_req ? (e_sel ? addr1 : addr0) : 32'h0;
            e_wdata = e_req ? (e_sel ? wdata1 : wdata0) : 32'h0;
            e_g0    = e_req && mem_ready && !e_sel;
            e_g1    = e_req && mem_ready && e_sel;
            e_pop   = mem_rvalid && m_q.size() > 0;
            e_orph_evt = mem_rvalid && m_q.size() == 0;
            e_rv0   = e_pop && m_q[0] == 0;
            e_rv1   = e_pop && m_q[0] == 1;
            total++;
            if ({gnt0, gnt1, rvalid0, rvalid1, mem_req, mem_we} !== {e_g0, e_g1, e_rv0, e_rv1, e_req, e_we}) begin
                bad++;
                $display("FAIL rand_ctrl c=%0d got g0g1rv0rv1reqwe=%b want=%b", c,
                         {gnt0, gnt1, rvalid0, rvalid1, mem_req, mem_we}, {e_g0, e_g1, e_rv0, e_rv1, e_req, e_we});
            end
            total++;
            if ({mem_addr, mem_wdata, rdata0, rdata1} !== {e_addr, e_wdata, mem_rdata, mem_rdata}) begin
                bad++;
                $display("FAIL rand_data c=%0d addr=%h wdata=%h want addr=%h wdata=%h", c, mem_addr, mem_wdata, e_addr, e_wdata);
            end
            total++;
            if ({outst_cnt, err_orphan} !== {3'(m_q.size()), m_orph}) begin
                bad++;
                $display("FAIL rand_state c=%0d cnt=%0d orphan=%b want cnt=%0d orphan=%b", c, outst_cnt, err_orphan, m_q.size(), m_orph);
            end
            @(posedge clk);
            if (e_orph_evt) m_orph = 1;
            if (e_pop) void'(m_q.pop_front());
            if (e_req && mem_ready) begin
                m_pref = e_sel ? 0 : 1;
                if (!e_we) m_q.push_back(e_sel ? 1 : 0);
                m_lock = -1;
            end else if (e_req) begin
                m_lock = e_sel ? 1 : 0;
            end
            #1;
            if (e_g0) req0 = 0;
            if (e_g1) req1 = 0;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_hold();
        test_fifo_full();
        test_orphan();
        test_reset_mid();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
